clkdiv_seq_ctrl: RTL and testbench

- Startup and calibration sequencer for the CLKDIV hard-macro divider wrapper; drives the divider's RESETN and CALIB inputs.
- Waits for a debounced PLL lock, holds the divider in reset, waits for the output to settle, then flags ready.
- Arbitrates calibration (CALIB) pulse requests with enforced minimum spacing.
- Sits between the PLL and the divider in the coil driver clock tree.

---
 rtl/clkdiv_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_clkdiv_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_seq_ctrl.sv
// Startup / calibration sequencer for the CLKDIV divider wrapper.
// Debounces PLL lock, sequences RESETN, spaces CALIB pulses.
module clkdiv_seq_ctrl #(
    parameter int PLL_FILTER    = 4,
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int CALIB_GAP     = 8
) (
    input  logic       hclkin,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       restart,
    input  logic       calib_req,
    input  logic       clear_err,
    output logic       div_resetn,
    output logic       div_calib,
    output logic       ready,
    output logic       calib_ack,
    output logic       lock_lost,
    output logic [2:0] state
);

    localparam int M1   = (PLL_FILTER > RESET_CYCLES) ? PLL_FILTER : RESET_CYCLES;
    localparam int M2   = (SETTLE_CYCLES > CALIB_GAP) ? SETTLE_CYCLES : CALIB_GAP;
    localparam int MAXP = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] FLT_LAST = CW'(PLL_FILTER - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] STL_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CALIB_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_SETTLE = 3'd2,
        S_READY  = 3'd3,
        S_CALIB  = 3'd4,
        S_GAP    = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            pend_q, pend_d;
    logic            lost_q, lost_d;
    logic            rstn_q, rdy_q, cal_q;
    logic            loss, powered;

    // Next-state, shared dwell counter, pending flag and sticky lock loss
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        loss    = (state_q != S_IDLE) && !pll_lock;
        powered = (state_q == S_SETTLE) || (state_q == S_READY) ||
                  (state_q == S_CALIB)  || (state_q == S_GAP);
        lost_d  = lost_q & ~clear_err;
        if (loss) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
            lost_d  = 1'b1;
        end else if (restart && powered) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!pll_lock) begin
                        cnt_d = '0;
                    end else if (cnt_q == FLT_LAST) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == STL_LAST) begin
                        state_d = S_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_READY: begin
                    if (calib_req || pend_q) begin
                        state_d = S_CALIB;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end
                end
                S_CALIB: begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    if (calib_req) pend_d = 1'b1;
                end
                S_GAP: begin
                    if (calib_req) pend_d = 1'b1;
                    if (cnt_q == GAP_LAST) begin
                        state_d = S_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counter and outputs registered from the next state
    always_ff @(posedge hclkin) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            lost_q  <= 1'b0;
            rstn_q  <= 1'b0;
            rdy_q   <= 1'b0;
            cal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
            rstn_q  <= (state_d == S_SETTLE) || (state_d == S_READY) ||
                       (state_d == S_CALIB)  || (state_d == S_GAP);
            rdy_q   <= (state_d == S_READY) || (state_d == S_CALIB) ||
                       (state_d == S_GAP);
            cal_q   <= (state_d == S_CALIB);
        end
    end

    assign div_resetn = rstn_q;
    assign ready      = rdy_q;
    assign div_calib  = cal_q;
    assign calib_ack  = cal_q;
    assign lock_lost  = lost_q;
    assign state      = state_q;

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Bench for clkdiv_seq_ctrl: directed test-plan scenarios plus
// random traffic against a dwell-time reference model.
module tb_clkdiv_seq_ctrl;

    localparam int PF = 4;
    localparam int RC = 16;
    localparam int SC = 64;
    localparam int CG = 8;

    logic       hclkin = 1'b0;
    logic       resetn, pll_lock, restart, calib_req, clear_err;
    logic       div_resetn, div_calib, ready, calib_ack, lock_lost;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // phase: 0 idle,1 hold,2 settle,3 ready,4 calib,5 gap
    int m_ph;
    int m_spent;
    bit m_pend;
    bit m_lost;

    clkdiv_seq_ctrl #(
        .PLL_FILTER(PF), .RESET_CYCLES(RC),
        .SETTLE_CYCLES(SC), .CALIB_GAP(CG)
    ) dut (
        .hclkin(hclkin), .resetn(resetn), .pll_lock(pll_lock),
        .restart(restart), .calib_req(calib_req),
        .clear_err(clear_err), .div_resetn(div_resetn),
        .div_calib(div_calib), .ready(ready),
        .calib_ack(calib_ack), .lock_lost(lock_lost), .state(state)
    );

    always #5 hclkin = ~hclkin;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dwell(input int ph);
        case (ph)
            0: return PF;
            1: return RC;
            2: return SC;
            5: return CG;
            default: return 1;
        endcase
    endfunction

    // One clock of the reference sequencer, from the current inputs
    task automatic model_step();
        bit nl;
        if (!resetn) begin
            m_ph = 0; m_spent = 0; m_pend = 0; m_lost = 0;
            return;
        end
        nl = m_lost && !clear_err;
        if (m_ph != 0 && !pll_lock) begin
            m_ph = 0; m_spent = 0; m_pend = 0; nl = 1;
        end else if (restart && m_ph >= 2) begin
            m_ph = 1; m_spent = 0; m_pend = 0;
        end else if (m_ph == 0) begin
            m_spent = pll_lock ? m_spent + 1 : 0;
            if (m_spent == dwell(0)) begin
                m_ph = 1; m_spent = 0;
            end
        end else if (m_ph == 3) begin
            if (calib_req || m_pend) begin
                m_ph = 4; m_pend = 0;
            end
        end else if (m_ph == 4) begin
            if (calib_req) m_pend = 1;
            m_ph = 5; m_spent = 0;
        end else begin
            if (m_ph == 5 && calib_req) m_pend = 1;
            m_spent++;
            if (m_spent == dwell(m_ph)) begin
                m_ph = (m_ph == 5) ? 3 : m_ph + 1;
                m_spent = 0;
            end
        end
        m_lost = nl;
    endtask

    function automatic logic [7:0] obs();
        return {state, div_resetn, ready, div_calib, calib_ack, lock_lost};
    endfunction

    function automatic logic [7:0] expv();
        logic [2:0] s;
        logic       rn, rd, cl;
        s  = m_ph[2:0];
        rn = (m_ph >= 2);
        rd = (m_ph >= 3);
        cl = (m_ph == 4);
        return {s, rn, rd, cl, cl, m_lost};
    endfunction

    task automatic cyc();
        model_step();
        @(posedge hclkin);
        #1;
        check("cycle", 32'(obs()), 32'(expv()));
    endtask

    // sel: 0 state==s, 1 div_resetn, 2 ready
    task automatic wait_for(input string tag, input int sel,
                            input logic [2:0] s, input int lim,
                            output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < lim) begin
            cyc();
            n++;
            case (sel)
                0: hit = (state == s);
                1: hit = div_resetn;
                default: hit = ready;
            endcase
        end
        if (!hit) check(tag, 32'(n), 32'(lim + 1));
    endtask

    int n, acks, a0, a1, holdc, setc;

    initial begin
        resetn = 0; pll_lock = 0; restart = 0;
        calib_req = 0; clear_err = 0;
        m_ph = 0; m_spent = 0; m_pend = 0; m_lost = 0;
        cyc(); cyc();
        check("reset_outs", 32'(obs()), 32'h0);

        resetn = 1; pll_lock = 1;
        wait_for("to_hold", 0, 3'd1, 50, n);
        check("hold_latency", 32'(n), 32'd4);
        wait_for("to_rstn", 1, 3'd0, 50, a0);
        check("rstn_latency", 32'(n + a0), 32'd20);
        wait_for("to_ready", 2, 3'd0, 100, a1);
        check("ready_latency", 32'(n + a0 + a1), 32'd84);

        acks = 0; a0 = -1; a1 = -1;
        for (int i = 0; i < 20; i++) begin
            calib_req = (i < 3);
            cyc();
            if (calib_ack) begin
                acks++;
                if (a0 < 0) a0 = i; else a1 = i;
            end
        end
        calib_req = 0;
        check("ack_count", 32'(acks), 32'd2);
        check("ack_first", 32'(a0), 32'd0);
        check("ack_pending", 32'(a1), 32'd10);

        calib_req = 1; cyc();
        calib_req = 0; cyc();
        calib_req = 1; cyc();
        calib_req = 0;
        check("in_gap", 32'(state), 32'd5);
        pll_lock = 0; cyc();
        check("loss_state", 32'(state), 32'd0);
        check("loss_flag", 32'(lock_lost), 32'd1);
        check("loss_outs", 32'({div_resetn, ready}), 32'd0);
        clear_err = 1; cyc();
        clear_err = 0;
        check("clear_err", 32'(lock_lost), 32'd0);

        for (int i = 0; i < 4; i++) begin
            pll_lock = (i != 3);
            cyc();
        end
        check("debounce_idle", 32'(state), 32'd0);
        pll_lock = 1;
        wait_for("rehold", 0, 3'd1, 50, n);
        check("debounce_hold", 32'(n), 32'd4);
        wait_for("reready", 2, 3'd0, 200, n);
        check("no_stale_calib", 32'(div_calib), 32'd0);

        restart = 1; cyc();
        restart = 0;
        check("restart_hold", 32'({state, div_resetn}), 32'({3'd1, 1'b0}));
        holdc = 1; setc = 0; acks = 0; n = 0;
        calib_req = 1;
        while (!ready && n < 200) begin
            cyc();
            calib_req = 0;
            n++;
            if (state == 3'd1) holdc++;
            if (state == 3'd2) setc++;
            if (calib_ack) acks++;
        end
        check("restart_hold_len", 32'(holdc), 32'd16);
        check("restart_settle_len", 32'(setc), 32'd64);
        check("hold_req_dropped", 32'(acks), 32'd0);

        restart = 1; cyc();
        restart = 0;
        wait_for("to_settle", 0, 3'd2, 50, n);
        for (int i = 0; i < 10; i++) cyc();
        resetn = 0; cyc();
        check("mid_reset", 32'(obs()), 32'h0);
        resetn = 1;
        wait_for("after_reset", 0, 3'd1, 50, n);
        check("after_reset_hold", 32'(n), 32'd4);

        for (int i = 0; i < 4000; i++) begin
            resetn    = ($urandom_range(499) != 0);
            pll_lock  = ($urandom_range(399) != 0);
            restart   = ($urandom_range(149) == 0);
            calib_req = ($urandom_range(4) == 0);
            clear_err = ($urandom_range(19) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
